// File: rtl/led_matrix_scan.sv
// led_matrix_scan: 8x8 bicolour LED matrix row scanner with per-frame grid snapshot and row blanking.
// Optional PWM brightness control is compiled in with SCAN_BRIGHTNESS_EN.
module led_matrix_scan #(
  parameter int ROW_CYCLES   = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic            clock,
  input  logic            rst,
  input  logic [7:0][7:0] green_grid,
  input  logic [7:0][7:0] blue_grid,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [2:0]      brightness,
`endif
  output logic [7:0]      row_anode,
  output logic [7:0]      green_cathode,
  output logic [7:0]      blue_cathode,
  output logic            frame_start
);
  localparam int DW = $clog2(ROW_CYCLES);
  localparam logic [DW-1:0] BLANK = DW'(BLANK_CYCLES);
  localparam logic [DW-1:0] PRE   = DW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] LAST  = DW'(ROW_CYCLES - 1);
  logic [2:0]      row;
  logic [DW-1:0]   dwell;
  logic [7:0][7:0] snap_green, snap_blue;
  logic            first, lit, show;
  assign first = row == '0 && dwell == '0;
  assign lit   = dwell >= BLANK;
`ifdef SCAN_BRIGHTNESS_EN
  logic [2:0] pwm, snap_bright;
  assign show = lit && pwm <= snap_bright;
  // pwm is zero in the first lit state of every row
  always_ff @(posedge clock)
    if (rst) begin
      pwm         <= '0;
      snap_bright <= '1;
    end else begin
      pwm <= dwell == PRE ? 3'd0 : pwm + 3'd1;
      if (first) snap_bright <= brightness;
    end
`else
  assign show = lit;
`endif
  always_ff @(posedge clock)
    if (rst) begin
      row           <= '0;
      dwell         <= '0;
      snap_green    <= '1;
      snap_blue     <= '1;
      row_anode     <= '0;
      green_cathode <= '1;
      blue_cathode  <= '1;
      frame_start   <= 1'b0;
    end else begin
      dwell <= dwell == LAST ? '0 : dwell + DW'(1);
      if (dwell == LAST) row <= row + 3'd1;
      if (first) begin
        snap_green <= green_grid;
        snap_blue  <= blue_grid;
      end
      frame_start   <= first;
      row_anode     <= lit ? 8'b1 << row : 8'h00;
      green_cathode <= show ? snap_green[row] : 8'hFF;
      blue_cathode  <= show ? snap_blue[row] : 8'hFF;
    end
endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: directed checks of scan order, blanking, snapshot timing, reset and brightness.
module tb_led_matrix_scan;
  logic            clock = 1'b0;
  logic            rst;
  logic [7:0][7:0] green_grid, blue_grid;
  logic [2:0]      brightness;
  logic [7:0]      row_anode, green_cathode, blue_cathode;
  logic            frame_start;
  int errors = 0, checks = 0, idx = 0;
  logic [7:0][7:0] sg = '1, sb = '1;
  logic [2:0]      sbr = 3'd7;

  led_matrix_scan #(.ROW_CYCLES(16), .BLANK_CYCLES(2)) dut (
    .clock(clock),
    .rst(rst),
    .green_grid(green_grid),
    .blue_grid(blue_grid),
`ifdef SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .row_anode(row_anode),
    .green_cathode(green_cathode),
    .blue_cathode(blue_cathode),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at idx %0d: got %h expected %h", tag, idx, got, exp);
    end
  endtask

  // Advance to the output shown for the next counter state; capture the expected snapshot at frame start.
  task automatic tick();
    if ((idx + 1) % 128 == 0) begin
      sg  = green_grid;
      sb  = blue_grid;
      sbr = brightness;
    end
    @(negedge clock);
    idx++;
  endtask

  task automatic check_scan();
    int r, d;
    logic on;
    logic [7:0] a, g, b;
    r  = (idx / 16) % 8;
    d  = idx % 16;
    on = d >= 2 && 3'(d - 2) <= sbr;
    a  = d >= 2 ? 8'(1 << r) : 8'h00;
    g  = on ? sg[r] : 8'hFF;
    b  = on ? sb[r] : 8'hFF;
    check8("anode", row_anode, a);
    check8("green", green_cathode, g);
    check8("blue", blue_cathode, b);
    check8("frame_start", {7'b0, frame_start}, {7'b0, idx % 128 == 0});
    check8("onehot", {7'b0, $onehot0(row_anode)}, 8'h01);
  endtask

  task automatic run_to(input int t);
    while (idx < t) begin
      tick();
      check_scan();
    end
  endtask

  initial begin
    int f;
    rst = 1'b1;
    brightness = 3'd7;
    green_grid = {$urandom, $urandom};
    blue_grid  = {$urandom, $urandom};
    repeat (3) @(negedge clock);
    check8("rst_anode", row_anode, 8'h00);
    check8("rst_green", green_cathode, 8'hFF);
    check8("rst_blue", blue_cathode, 8'hFF);
    check8("rst_fs", {7'b0, frame_start}, 8'h00);
    for (int r = 0; r < 8; r++) green_grid[r] = ~(8'b1 << r);
    blue_grid = '1;
    rst = 1'b0;
    idx = -1;
    run_to(0);
    check8("fs_first", {7'b0, frame_start}, 8'h01);
    run_to(1);
    check8("blank_anode", row_anode, 8'h00);
    run_to(53);
    check8("row3_anode", row_anode, 8'h08);
    check8("row3_green", green_cathode, 8'hF7);
    run_to(120);
    green_grid = '1;
    run_to(128);
    check8("fs_period", {7'b0, frame_start}, 8'h01);
    run_to(180);
    green_grid[5] = 8'h00;
    run_to(213);
    check8("coh_anode", row_anode, 8'h20);
    check8("coh_old", green_cathode, 8'hFF);
    run_to(341);
    check8("coh_new", green_cathode, 8'h00);
    run_to(383);
    green_grid[2] = 8'hA5;
    run_to(384);
    green_grid[6] = 8'h3C;
    run_to(421);
    check8("snap_same", green_cathode, 8'hA5);
    run_to(485);
    check8("late_old", green_cathode, 8'hFF);
    run_to(500);
    green_grid[7] = 8'h7F;
    blue_grid[7]  = 8'hBF;
    run_to(613);
    check8("late_new", green_cathode, 8'h3C);
    run_to(632);
    check8("both_anode", row_anode, 8'h80);
    check8("both_green", green_cathode, 8'h7F);
    check8("both_blue", blue_cathode, 8'hBF);
    f = 640;
`ifdef SCAN_BRIGHTNESS_EN
    run_to(633);
    brightness = 3'd1;
    green_grid = '0;
    blue_grid  = '0;
    for (int d = 2; d < 16; d++) begin
      run_to(640 + d);
      check8("pwm1_anode", row_anode, 8'h01);
      check8("pwm1_green", green_cathode, ((d - 2) % 8) < 2 ? 8'h00 : 8'hFF);
    end
    run_to(760);
    brightness = 3'd7;
    for (int d = 2; d < 16; d++) begin
      run_to(768 + d);
      check8("pwm7_green", green_cathode, 8'h00);
    end
    f = 896;
`endif
    run_to(f + 70);
    check8("pre_rst_anode", row_anode, 8'h10);
    rst = 1'b1;
    @(negedge clock);
    check8("mid_rst_anode", row_anode, 8'h00);
    check8("mid_rst_green", green_cathode, 8'hFF);
    check8("mid_rst_blue", blue_cathode, 8'hFF);
    check8("mid_rst_fs", {7'b0, frame_start}, 8'h00);
    @(negedge clock);
    rst = 1'b0;
    idx = -1;
    run_to(0);
    check8("restart_fs", {7'b0, frame_start}, 8'h01);
    run_to(18);
    check8("restart_row1", row_anode, 8'h02);
    run_to(130);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Time-multiplexed scan driver for the 8x8 bicolour LED matrix. It consumes the `green_grid` and `blue_grid` state produced by the game-state logic, one active-low cathode byte per row. It drives the physical matrix one row at a time, with anode select and per-colour cathodes. Each frame is taken from a coherent snapshot, and a blanking interval at every row change suppresses ghosting.

## Interface
- `ROW_CYCLES`, default 16: clocks per row dwell, including blanking. Legal range is 2..65535.
- `BLANK_CYCLES`, default 2: clocks at the start of each dwell with the matrix dark. Legal range is 1..ROW_CYCLES-1.
- `clock`, input, 1: single system clock. All logic is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `green_grid`, input, [7:0][7:0]: green state. Row index r, column bit c. 0 = LED lit.
- `blue_grid`, input, [7:0][7:0]: blue state, same encoding as `green_grid`.
- `brightness`, input, 3: PWM duty, 0 = 1/8 up to 7 = 8/8. Present only with `SCAN_BRIGHTNESS_EN`.
- `row_anode`, output, 8: one-hot, active-high. Bit r enables matrix row r.
- `green_cathode`, output, 8: active-low green column drive.
- `blue_cathode`, output, 8: active-low blue column drive.
- `frame_start`, output, 1: single-cycle pulse at the start of every frame.

## Operation
- **Internal counters:**
  - `row` is 3 bits.
  - `dwell` counts 0..ROW_CYCLES-1 and is ceil(log2(ROW_CYCLES)) bits.
  - Each clock, `dwell` increments. At ROW_CYCLES-1 it wraps to 0 and `row` increments. `row` wraps 7 -> 0.
- **Snapshot:**
  - In the cycle with `row`=0 and `dwell`=0, both grids (and `brightness` if compiled in) are copied into snapshot registers.
  - Input changes at any other time have no effect until the next frame.
- **Phases, per counter state:**
  - Blank, when `dwell` < BLANK_CYCLES: `row_anode`=0x00 and both cathodes are 0xFF.
  - Lit, otherwise: `row_anode` = 1<<`row`, `green_cathode` = snap_green[`row`], `blue_cathode` = snap_blue[`row`].
- **Column mapping:** cathode bit c equals grid bit c, with no reordering. Grid row 0 (the cursor row) is scanned first.
- **`frame_start`:** asserted for the counter state `row`=0 and `dwell`=0.
- **Reset:**
  - Counters go to 0 and the snapshot goes to all 1s.
  - Outputs go to `row_anode`=0x00, cathodes=0xFF, `frame_start`=0.
  - Reset asserted mid-frame darkens the matrix on the next edge.
  - The scan restarts at row 0 in the cycle after `rst` deasserts, and that cycle's state loads the snapshot.
- **Invariants:**
  - At most one `row_anode` bit is ever set.
  - Cathodes are 0xFF whenever `row_anode` is 0x00.

## Timing
- All outputs are registered. Output at edge k+1 reflects counter and snapshot state at edge k, so there is one cycle of latency.
- Frame period is 8*ROW_CYCLES clocks. `frame_start` repeats exactly at that period.
- The snapshot loads at the end of the blank cycle `row`=0, `dwell`=0. Because BLANK_CYCLES>=1, row 0's lit phase always uses the new snapshot.
- A grid change arriving in the same cycle as the snapshot load is captured.
- A grid change one cycle later appears a full frame later.
- Lit duration per row is ROW_CYCLES-BLANK_CYCLES clocks.

## Configuration
- `SCAN_BRIGHTNESS_EN` defined:
  - The `brightness` port exists and is snapshotted with the grids.
  - A 3-bit PWM counter resets to 0 at the first lit cycle of each row and increments every clock, wrapping.
  - During the lit phase the anode stays on. Cathodes show snapshot data when pwm ≤ snap_brightness and are forced to 0xFF otherwise.
  - brightness=7 is identical to the non-macro build.
- `SCAN_BRIGHTNESS_EN` undefined: no port and no PWM logic. The full lit phase is always driven.

## Test plan
All scenarios use ROW_CYCLES=16 and BLANK_CYCLES=2 (frame = 128 clocks).
- **Reset values.** Hold `rst` 3 cycles with random grids. Required: `row_anode`=0x00, cathodes=0xFF, `frame_start`=0. Release; `frame_start` pulses once, then repeats every 128 clocks.
- **Scan order and blanking.**
  - Stimulus: green_grid[r] = ~(1<<r), blue all 0xFF.
  - Per row r: 2 dark clocks, then 14 clocks with `row_anode`=1<<r and `green_cathode`=~(1<<r).
  - `blue_cathode` stays 0xFF throughout, and a one-hot check holds every cycle.
- **Snapshot coherence.**
  - Change green_grid[5] from 0xFF to 0x00 while row 3 is lit. Required: row 5 still shows 0xFF this frame and shows 0x00 the next frame.
  - Change the grid exactly in the snapshot cycle. Required: it is captured the same frame.
- **Reset mid-frame.** Assert `rst` during row 4 lit. Required: dark on the next edge. After release, scanning restarts at row 0 with a `frame_start` pulse.
- **Both colours.** green_grid[7]=0x7F and blue_grid[7]=0xBF. Required: during row 7 lit, `green_cathode`=0x7F and `blue_cathode`=0xBF simultaneously.
- **Brightness (`SCAN_BRIGHTNESS_EN`).** Set brightness=1 with all grids 0x00. Required: per row, 14 lit clocks with the anode on throughout and the cathode pattern 0x00,0x00 followed by six clocks of 0xFF, repeating. brightness=7 gives 14 clocks of 0x00.
